// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared FSM state type and round-robin pointer helper for the arbiter.
package rr_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
  function automatic int next_rr(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction
endpackage

// File: rtl/sync_bank.sv
// sync_bank: two-flop synchronizer vector for asynchronous inputs.
module sync_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/rr_sync_arbiter.sv
// rr_sync_arbiter: round-robin arbiter over synchronized async requests with a hold-time limit.
module rr_sync_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] async_req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout
);
  logic [NUM_REQ-1:0] sreq, elig, lockout, lockout_n, grant_n;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_n, sel, idx, grant_id_n;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
  logic               busy_n, timeout_n;
  arb_state_t         state, state_n;
  sync_bank #(.WIDTH(NUM_REQ)) u_sync (.clk(clk), .rst(rst), .d(async_req), .q(sreq));
  assign elig = sreq & ~lockout;
  // Descending scan so the eligible index closest to rr_ptr is written last.
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      idx = ID_W'((int'(rr_ptr) + j) % NUM_REQ);
      if (elig[idx]) sel = idx;
    end
  end
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    grant_id_n = grant_id;
    busy_n     = busy;
    timeout_n  = 1'b0;
    rr_ptr_n   = rr_ptr;
    hold_cnt_n = hold_cnt;
    lockout_n  = lockout & sreq;
    case (state)
      IDLE: if (|elig) begin
        state_n    = GRANT;
        grant_n    = NUM_REQ'(1) << sel;
        grant_id_n = sel;
        busy_n     = 1'b1;
        hold_cnt_n = CNT_W'(1);
      end
      GRANT: if (!sreq[grant_id] || hold_cnt == CNT_W'(MAX_HOLD)) begin
        state_n   = GAP;
        grant_n   = '0;
        busy_n    = 1'b0;
        rr_ptr_n  = ID_W'(next_rr(int'(grant_id), NUM_REQ));
        // A still-requesting owner here means the hold limit fired.
        timeout_n = sreq[grant_id];
        if (sreq[grant_id]) lockout_n[grant_id] = 1'b1;
      end else begin
        hold_cnt_n = hold_cnt + 1'b1;
      end
      default: begin
        state_n    = IDLE;
        grant_id_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      lockout  <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
      rr_ptr   <= rr_ptr_n;
      hold_cnt <= hold_cnt_n;
      lockout  <= lockout_n;
    end
  end
endmodule

// File: tb/tb_rr_sync_arbiter.sv
// tb_rr_sync_arbiter: scoreboard bench; stimulus queues grant/release/timeout events, a monitor pops them.
module tb_rr_sync_arbiter;
  localparam int N = 4;
  localparam int MH = 16;
  localparam int GNT = 0, REL = 1, TMO = 2;
  typedef struct {
    int         kind;
    logic [N-1:0] g;
    logic [1:0] id;
    int         at;
  } ev_t;
  logic         tb_clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] async_req = '1;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy, timeout;
  ev_t          exp_q[$];
  int           n_cmp = 0, n_bad = 0, cyc = 0;
  bit           sb_on = 1'b1;
  logic [N-1:0] prev_g = '0;
  rr_sync_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(tb_clk), .rst(rst), .async_req(async_req),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );
  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;
  task automatic expect_ev(input int kind, input logic [N-1:0] g, input logic [1:0] id, input int at);
    ev_t e;
    e.kind = kind; e.g = g; e.id = id; e.at = at;
    exp_q.push_back(e);
  endtask
  task automatic got_ev(input int kind, input logic [N-1:0] g, input logic [1:0] id);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event got kind=%0d grant=%b id=%0d cyc=%0d, required none", kind, g, id, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.g != g || e.id != id || e.at != cyc) begin
        n_bad++;
        $display("FAIL event got kind=%0d grant=%b id=%0d cyc=%0d, required kind=%0d grant=%b id=%0d cyc=%0d",
                 kind, g, id, cyc, e.kind, e.g, e.id, e.at);
      end
    end
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got %0h required %0h (cyc=%0d)", name, got, req, cyc);
    end
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge tb_clk);
  endtask
  // Monitor: invariant every cycle, scoreboard events on grant edges and timeout pulses.
  always @(negedge tb_clk) begin
    n_cmp++;
    if ($countones(grant) > 1 || busy !== (grant != '0) || (grant != '0 && grant !== (N'(1) << grant_id))) begin
      n_bad++;
      $display("FAIL grant_invariant got grant=%b id=%0d busy=%b, required one-hot/zero grant matching id and busy", grant, grant_id, busy);
    end
    if (sb_on) begin
      if (prev_g != '0 && grant != prev_g) got_ev(REL, prev_g, 2'd0);
      if (grant != '0 && grant != prev_g) got_ev(GNT, grant, grant_id);
      if (timeout) got_ev(TMO, '0, 2'd0);
    end
    prev_g <= grant;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got no finish, required finish before time limit");
    $fatal(1);
  end
  initial begin
    int c, g, t;
    logic [N-1:0] oh;
    repeat (2) begin
      @(negedge tb_clk);
      chk("reset_outputs", 32'({grant, grant_id, busy, timeout}), 0);
    end
    // Reset release with all lines high: requester 0 wins three edges later.
    rst = 1'b0; c = cyc;
    expect_ev(GNT, 4'b0001, 2'd0, c + 3);
    expect_ev(REL, 4'b0001, 2'd0, c + 6);
    wait_to(c + 3); async_req = '0;
    wait_to(c + 12);
    // Single request and release, then GAP back to idle.
    c = cyc; async_req = 4'b0100;
    expect_ev(GNT, 4'b0100, 2'd2, c + 3);
    expect_ev(REL, 4'b0100, 2'd0, c + 6);
    wait_to(c + 3); async_req = '0;
    wait_to(c + 7);
    chk("idle_after_gap", 32'({busy, grant_id}), 0);
    wait_to(c + 10);
    // Fairness: owners blip their line, order must be 0,1,2,3,0.
    rst = 1'b1; @(negedge tb_clk);
    rst = 1'b0; async_req = '1; c = cyc; g = c + 3;
    for (int i = 0; i < 5; i++) begin
      oh = N'(1) << (i % 4);
      expect_ev(GNT, oh, 2'(i % 4), g + 7 * i);
      expect_ev(REL, oh, 2'd0, g + 7 * i + 5);
    end
    for (int i = 0; i < 5; i++) begin
      wait_to(g + 7 * i + 2);
      if (i < 4) begin
        async_req[i % 4] = 1'b0;
        @(negedge tb_clk);
        async_req[i % 4] = 1'b1;
      end else async_req = '0;
    end
    wait_to(g + 45);
    // Hold limit: 16 cycles, timeout pulse, lockout until the line drops.
    c = cyc; async_req = 4'b0010; t = c + 40;
    expect_ev(GNT, 4'b0010, 2'd1, c + 3);
    expect_ev(REL, 4'b0010, 2'd0, c + 19);
    expect_ev(TMO, '0, 2'd0, c + 19);
    expect_ev(GNT, 4'b0010, 2'd1, t + 4);
    expect_ev(REL, 4'b0010, 2'd0, t + 7);
    wait_to(t); async_req = '0;
    @(negedge tb_clk); async_req = 4'b0010;
    wait_to(t + 4); async_req = '0;
    wait_to(t + 12);
    // Timeout with a waiter: 0 times out, 1 follows after one GAP cycle, 0 stays locked.
    c = cyc; async_req = 4'b0011;
    expect_ev(GNT, 4'b0001, 2'd0, c + 3);
    expect_ev(REL, 4'b0001, 2'd0, c + 19);
    expect_ev(TMO, '0, 2'd0, c + 19);
    expect_ev(GNT, 4'b0010, 2'd1, c + 21);
    expect_ev(REL, 4'b0010, 2'd0, c + 24);
    wait_to(c + 21); async_req = 4'b0001;
    wait_to(c + 45);
    chk("lockout_holds", 32'(grant), 0);
    async_req = '0;
    wait_to(c + 52);
    // Reset during a grant drops it at that edge; regrant needs a fresh sync.
    c = cyc; async_req = 4'b0100;
    expect_ev(GNT, 4'b0100, 2'd2, c + 3);
    expect_ev(REL, 4'b0100, 2'd0, c + 6);
    wait_to(c + 5); rst = 1'b1;
    wait_to(c + 6);
    chk("midgrant_reset", 32'({grant, grant_id, busy, timeout}), 0);
    rst = 1'b0;
    expect_ev(GNT, 4'b0100, 2'd2, c + 9);
    expect_ev(REL, 4'b0100, 2'd0, c + 12);
    wait_to(c + 9); async_req = '0;
    wait_to(c + 16);
    // Random toggling: only the invariant is checked.
    sb_on = 1'b0;
    repeat (100) begin
      @(negedge tb_clk);
      async_req = N'($urandom);
    end
    async_req = '0;
    repeat (25) @(negedge tb_clk);
    sb_on = 1'b1;
    // Transition just after an edge still yields a grant three edges later.
    c = cyc;
    @(posedge tb_clk); #1 async_req = 4'b0001;
    expect_ev(GNT, 4'b0001, 2'd0, c + 4);
    expect_ev(REL, 4'b0001, 2'd0, c + 7);
    wait_to(c + 4); async_req = '0;
    wait_to(c + 12);
    chk("events_pending", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
